// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the mox125 instruction-fetch sequencer.
// State encoding and fetch-address step size.
package cpu_fetch_pkg;

    typedef enum logic [2:0] {
        REDIRECT = 3'd0,
        ISSUE    = 3'd1,
        WAITACK  = 3'd2,
        PUSH     = 3'd3,
        DRAIN    = 3'd4
    } state_t;

    localparam logic [31:0] WORD_INC = 32'd4;

endpackage

// File: rtl/cpu_fetch_ctrl_if.sv
// Instruction-bus and instruction-FIFO bundle of the fetch sequencer.
// master = cpu_fetch_ctrl, slave = bus/FIFO side.
interface cpu_fetch_ctrl_if;

    logic [31:0] wb_adr_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        ififo_full_i;
    logic        ififo_rst_o;
    logic        ififo_we_o;
    logic [31:0] ififo_data_o;
    logic        ififo_newpc_o;
    logic [31:0] ififo_pc_o;

    modport master (
        output wb_adr_o, wb_cyc_o, wb_stb_o,
        output ififo_rst_o, ififo_we_o, ififo_data_o,
        output ififo_newpc_o, ififo_pc_o,
        input  wb_dat_i, wb_ack_i, ififo_full_i
    );

    modport slave (
        input  wb_adr_o, wb_cyc_o, wb_stb_o,
        input  ififo_rst_o, ififo_we_o, ififo_data_o,
        input  ififo_newpc_o, ififo_pc_o,
        output wb_dat_i, wb_ack_i, ififo_full_i
    );

endinterface

// File: rtl/fetch_realign.sv
// Halfword realignment for fetches that start at an odd-halfword target.
// Keeps the low half of the previous word and splices it ahead of the next.
module fetch_realign (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        align,
    input  logic        load,
    input  logic [31:0] dat,
    output logic [31:0] data
);

    logic [15:0] hold;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hold <= '0;
        end else if (load && align) begin
            hold <= dat[15:0];
        end
    end

    assign data = align ? {hold, dat[31:16]} : dat;

endmodule

// File: rtl/cpu_fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding Wishbone read at a time,
// words pushed into cpu_ififo, with boot and branch redirects.
module cpu_fetch_ctrl
    import cpu_fetch_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_1000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             branch_p_i,
    input  logic [31:0]      branch_target_i,
    input  logic             stall_i,
    cpu_fetch_ctrl_if.master bus
);

    state_t      state;
    logic [31:0] fetch_adr;
    logic [31:1] pend_target;
    logic        pend;
    logic        align;
    logic        first;
    logic [31:0] rdata;
    logic        load;
    logic        can_issue;
    logic        unused_tgt0;

    assign unused_tgt0 = branch_target_i[0];
    assign can_issue   = !bus.ififo_full_i && !stall_i;
    assign load        = (state == WAITACK) && bus.wb_ack_i && !branch_p_i;

    fetch_realign u_realign (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .align (align),
        .load  (load),
        .dat   (bus.wb_dat_i),
        .data  (rdata)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state             <= REDIRECT;
            fetch_adr         <= BOOT_ADDRESS;
            pend_target       <= BOOT_ADDRESS[31:1];
            pend              <= 1'b0;
            align             <= 1'b0;
            first             <= 1'b0;
            bus.wb_adr_o      <= BOOT_ADDRESS;
            bus.wb_cyc_o      <= 1'b0;
            bus.wb_stb_o      <= 1'b0;
            bus.ififo_rst_o   <= 1'b0;
            bus.ififo_we_o    <= 1'b0;
            bus.ififo_data_o  <= '0;
            bus.ififo_newpc_o <= 1'b0;
            bus.ififo_pc_o    <= BOOT_ADDRESS;
        end else begin
            // latest branch wins until the redirect consumes it
            if (branch_p_i) begin
                pend        <= 1'b1;
                pend_target <= branch_target_i[31:1];
            end

            if (bus.ififo_rst_o) begin
                bus.ififo_rst_o   <= 1'b0;
                bus.ififo_newpc_o <= 1'b1;
            end else if (bus.ififo_newpc_o && !stall_i) begin
                bus.ififo_newpc_o <= 1'b0;
            end

            case (state)
                REDIRECT: begin
                    if (!branch_p_i) begin
                        bus.ififo_rst_o   <= 1'b1;
                        bus.ififo_newpc_o <= 1'b0;
                        bus.ififo_pc_o    <= {pend_target, 1'b0};
                        fetch_adr         <= {pend_target[31:2], 2'b00};
                        align             <= pend_target[1];
                        first             <= pend_target[1];
                        pend              <= 1'b0;
                        state             <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (branch_p_i || pend) begin
                        state <= REDIRECT;
                    end else if (can_issue) begin
                        bus.wb_cyc_o <= 1'b1;
                        bus.wb_stb_o <= 1'b1;
                        bus.wb_adr_o <= fetch_adr;
                        state        <= WAITACK;
                    end
                end
                WAITACK: begin
                    if (bus.wb_ack_i) begin
                        bus.wb_cyc_o <= 1'b0;
                        bus.wb_stb_o <= 1'b0;
                        fetch_adr    <= fetch_adr + WORD_INC;
                        if (branch_p_i) begin
                            state <= REDIRECT;
                        end else if (align && first) begin
                            first <= 1'b0;
                            state <= ISSUE;
                        end else begin
                            bus.ififo_we_o   <= 1'b1;
                            bus.ififo_data_o <= rdata;
                            state            <= PUSH;
                        end
                    end else if (branch_p_i) begin
                        state <= DRAIN;
                    end
                end
                PUSH: begin
                    if (branch_p_i) begin
                        bus.ififo_we_o <= 1'b0;
                        state          <= REDIRECT;
                    end else if (!stall_i) begin
                        // write retires this edge; chain straight into the next read
                        bus.ififo_we_o <= 1'b0;
                        if (!bus.ififo_full_i) begin
                            bus.wb_cyc_o <= 1'b1;
                            bus.wb_stb_o <= 1'b1;
                            bus.wb_adr_o <= fetch_adr;
                            state        <= WAITACK;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.wb_ack_i) begin
                        bus.wb_cyc_o <= 1'b0;
                        bus.wb_stb_o <= 1'b0;
                        state        <= REDIRECT;
                    end
                end
                default: state <= REDIRECT;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_fetch_ctrl.sv
// Directed bench for cpu_fetch_ctrl: boot vector table plus
// hand sequences for backpressure, stall, branches and async reset.
module tb_cpu_fetch_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        branch_p_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        stall_i = 1'b0;

    cpu_fetch_ctrl_if bus ();

    cpu_fetch_ctrl #(.BOOT_ADDRESS(32'h0000_1000)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .branch_p_i      (branch_p_i),
        .branch_target_i (branch_target_i),
        .stall_i         (stall_i),
        .bus             (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;
    int wait_n = 0;
    int cnt;
    logic [31:0] wr_q[$];
    logic [31:0] rd_q[$];

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h3000) return 32'hAAAA_1111;
        if (a == 32'h3004) return 32'h2222_3333;
        return a ^ 32'hC0DE_0000;
    endfunction

    // memory: registered ack after wait_n extra cycles
    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bus.wb_ack_i <= 1'b0;
            bus.wb_dat_i <= '0;
            cnt          <= 0;
        end else if (bus.wb_cyc_o && bus.wb_stb_o && !bus.wb_ack_i) begin
            if (cnt >= wait_n) begin
                bus.wb_ack_i <= 1'b1;
                bus.wb_dat_i <= mem(bus.wb_adr_o);
                cnt          <= 0;
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            bus.wb_ack_i <= 1'b0;
        end
    end

    always @(posedge clk_i) begin
        if (rst_i && bus.ififo_we_o && !stall_i)
            wr_q.push_back(bus.ififo_data_o);
        if (rst_i && bus.wb_cyc_o && bus.wb_stb_o && bus.wb_ack_i)
            rd_q.push_back(bus.wb_adr_o);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_for(input int what, input logic [31:0] a,
                            input string nm);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_i);
            case (what)
                0: ok = bus.ififo_we_o;
                1: ok = bus.ififo_rst_o;
                2: ok = bus.ififo_newpc_o;
                3: ok = bus.wb_cyc_o && (bus.wb_adr_o == a);
                4: ok = (wr_q.size() >= int'(a));
                5: ok = bus.wb_cyc_o;
                default: ok = 1'b0;
            endcase
            if (ok) break;
        end
        chk(nm, ok, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        stall_i = 1'b0;
        branch_p_i = 1'b0;
        bus.ififo_full_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    typedef struct {
        logic        stall;
        logic        full;
        logic        rst;
        logic        npc;
        logic        cyc;
        logic        we;
        logic [31:0] adr;
        logic [31:0] data;
    } vec_t;

    localparam int NV = 16;
    vec_t tv[NV];

    function automatic vec_t v(logic s, logic f, logic r, logic n,
                               logic c, logic w, logic [31:0] ad,
                               logic [31:0] d);
        vec_t x;
        x.stall = s; x.full = f; x.rst = r; x.npc = n;
        x.cyc = c; x.we = w; x.adr = ad; x.data = d;
        return x;
    endfunction

    initial begin
        int m;
        int r;
        logic saw_we;

        //           st f  rst npc cyc we adr           data
        tv[0]  = v(0, 0, 1, 0, 0, 0, 32'h1000, 32'h0);
        tv[1]  = v(0, 0, 0, 1, 1, 0, 32'h1000, 32'h0);
        tv[2]  = v(0, 0, 0, 0, 1, 0, 32'h1000, 32'h0);
        tv[3]  = v(0, 0, 0, 0, 0, 1, 32'h1000, 32'hC0DE_1000);
        tv[4]  = v(0, 0, 0, 0, 1, 0, 32'h1004, 32'h0);
        tv[5]  = v(0, 0, 0, 0, 1, 0, 32'h1004, 32'h0);
        tv[6]  = v(0, 0, 0, 0, 0, 1, 32'h1004, 32'hC0DE_1004);
        tv[7]  = v(0, 0, 0, 0, 1, 0, 32'h1008, 32'h0);
        tv[8]  = v(0, 0, 0, 0, 1, 0, 32'h1008, 32'h0);
        tv[9]  = v(1, 0, 0, 0, 0, 1, 32'h1008, 32'hC0DE_1008);
        tv[10] = v(0, 1, 0, 0, 0, 1, 32'h1008, 32'hC0DE_1008);
        tv[11] = v(0, 1, 0, 0, 0, 0, 32'h1008, 32'h0);
        tv[12] = v(0, 0, 0, 0, 0, 0, 32'h1008, 32'h0);
        tv[13] = v(0, 0, 0, 0, 1, 0, 32'h100C, 32'h0);
        tv[14] = v(0, 0, 0, 0, 1, 0, 32'h100C, 32'h0);
        tv[15] = v(0, 0, 0, 0, 0, 1, 32'h100C, 32'hC0DE_100C);

        bus.ififo_full_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_cyc", bus.wb_cyc_o, 1'b0);
        chk("rst_stb", bus.wb_stb_o, 1'b0);
        chk("rst_we", bus.ififo_we_o, 1'b0);
        chk("rst_frst", bus.ififo_rst_o, 1'b0);
        chk("rst_npc", bus.ififo_newpc_o, 1'b0);
        chk("rst_adr", bus.wb_adr_o, 32'h1000);
        chk("rst_pc", bus.ififo_pc_o, 32'h1000);
        chk("rst_data", bus.ififo_data_o, 32'h0);
        rst_i = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk_i);
            chk($sformatf("v%0d_frst", i), bus.ififo_rst_o, tv[i].rst);
            chk($sformatf("v%0d_npc", i), bus.ififo_newpc_o, tv[i].npc);
            chk($sformatf("v%0d_cyc", i), bus.wb_cyc_o, tv[i].cyc);
            chk($sformatf("v%0d_stb", i), bus.wb_stb_o, tv[i].cyc);
            chk($sformatf("v%0d_we", i), bus.ififo_we_o, tv[i].we);
            chk($sformatf("v%0d_adr", i), bus.wb_adr_o, tv[i].adr);
            chk($sformatf("v%0d_pc", i), bus.ififo_pc_o, 32'h1000);
            if (tv[i].we)
                chk($sformatf("v%0d_data", i), bus.ififo_data_o, tv[i].data);
            stall_i = tv[i].stall;
            bus.ififo_full_i = tv[i].full;
        end

        // backpressure after the first push
        wait_n = 0;
        do_reset();
        wait_for(0, 0, "bp_first_we");
        bus.ififo_full_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk($sformatf("bp_nostb%0d", i), bus.wb_stb_o, 1'b0);
        end
        bus.ififo_full_i = 1'b0;
        @(negedge clk_i);
        chk("bp_stb", bus.wb_stb_o, 1'b1);
        chk("bp_adr", bus.wb_adr_o, 32'h1004);

        // stall holds the write for four cycles
        do_reset();
        wait_for(0, 0, "st_first_we");
        stall_i = 1'b1;
        m = wr_q.size();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk($sformatf("st_we%0d", i), bus.ififo_we_o, 1'b1);
            chk($sformatf("st_data%0d", i), bus.ififo_data_o, 32'hC0DE_1000);
        end
        stall_i = 1'b0;
        @(negedge clk_i);
        chk("st_we_drop", bus.ififo_we_o, 1'b0);
        chk("st_accepts", wr_q.size() - m, 1);
        chk("st_word0", wr_q[m], 32'hC0DE_1000);
        wait_for(4, m + 2, "st_second");
        chk("st_word1", wr_q[m + 1], 32'hC0DE_1004);

        // branch while a slow read is in flight
        wait_n = 2;
        do_reset();
        wait_for(3, 32'h1008, "bf_rd1008");
        m = wr_q.size();
        r = rd_q.size();
        branch_p_i = 1'b1;
        branch_target_i = 32'h2000;
        @(negedge clk_i);
        branch_p_i = 1'b0;
        chk("bf_cyc_held", bus.wb_cyc_o, 1'b1);
        saw_we = bus.ififo_we_o;
        for (int i = 0; i < 20 && !bus.ififo_rst_o; i++) begin
            @(negedge clk_i);
            saw_we |= bus.ififo_we_o;
        end
        chk("bf_flush", bus.ififo_rst_o, 1'b1);
        chk("bf_no_we", saw_we, 1'b0);
        wait_for(2, 0, "bf_newpc");
        chk("bf_pc", bus.ififo_pc_o, 32'h2000);
        wait_for(4, m + 1, "bf_write");
        chk("bf_drained", rd_q[r], 32'h1008);
        chk("bf_rd2000", rd_q[r + 1], 32'h2000);
        chk("bf_word", wr_q[m], 32'hC0DE_2000);

        // odd-halfword target
        wait_n = 0;
        do_reset();
        wait_for(0, 0, "od_first_we");
        branch_p_i = 1'b1;
        branch_target_i = 32'h3002;
        @(negedge clk_i);
        branch_p_i = 1'b0;
        m = wr_q.size();
        r = rd_q.size();
        wait_for(2, 0, "od_newpc");
        chk("od_pc", bus.ififo_pc_o, 32'h3002);
        wait_for(4, m + 1, "od_write");
        chk("od_word", wr_q[m], 32'h1111_2222);
        chk("od_reads", rd_q.size() - r, 2);
        chk("od_rd3000", rd_q[r], 32'h3000);

        // two branches two cycles apart
        do_reset();
        wait_for(0, 0, "db_first_we");
        r = rd_q.size();
        branch_p_i = 1'b1;
        branch_target_i = 32'h4000;
        @(negedge clk_i);
        branch_p_i = 1'b0;
        @(negedge clk_i);
        branch_p_i = 1'b1;
        branch_target_i = 32'h5000;
        @(negedge clk_i);
        branch_p_i = 1'b0;
        m = wr_q.size();
        wait_for(4, m + 2, "db_writes");
        chk("db_rd0", rd_q[r], 32'h5000);
        chk("db_rd1", rd_q[r + 1], 32'h5004);
        chk("db_word", wr_q[m], 32'hC0DE_5000);
        chk("db_pc", bus.ififo_pc_o, 32'h5000);

        // async reset in the middle of a bus cycle
        wait_n = 2;
        do_reset();
        wait_for(5, 0, "ar_cyc");
        #2;
        rst_i = 1'b0;
        #1;
        chk("ar_cyc_drop", bus.wb_cyc_o, 1'b0);
        chk("ar_stb_drop", bus.wb_stb_o, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b1;
        wait_for(5, 0, "ar_refetch");
        chk("ar_adr", bus.wb_adr_o, 32'h1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
